// File: rtl/out_mem_rd_ctrl_pkg.sv
// Purpose : shared types for the output-memory readback engine (FSM states, word tags).
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   BUF_DEPTH - depth of the output skid buffer (fixed at 2, sized to cover the
//               1-cycle memory read latency without bubbles)
//   CNT_W     - width of the buffer occupancy count
//   IDX_W     - width of the row / tile-column tags carried with each word
//   state_e   - readback FSM states
//   tag_t     - per-word side information {row, tile_col, last}
package out_mem_rd_ctrl_pkg;

  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  typedef struct packed {
    logic [IDX_W-1:0] row;
    logic [IDX_W-1:0] tile_col;
    logic             last;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/out_skid_buf.sv
// Purpose : 2-entry FIFO holding {word, tag} between the memory read port and the host.
// Latency : push at edge N is visible at the head (empty_o=0) in the cycle after edge N.
// Backpressure: push is dropped when full unless a pop happens in the same cycle
//               (push+pop on a full buffer keeps occupancy unchanged).
//
// Ports:
//   clk_i, rstn_i         - clock, asynchronous active-low reset (empties the buffer)
//   push_i, push_dat_i    - write request and data
//   pop_i                 - remove head entry (ignored when empty)
//   head_dat_o            - current head entry (all zeros after reset)
//   full_o, empty_o       - occupancy flags
//   count_o               - number of stored entries
module out_skid_buf
  import out_mem_rd_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             push_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  // Two entries, so single-bit pointers that simply toggle.
  logic [W-1:0]     mem_q [BUF_DEPTH];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o     = (cnt_q == CNT_W'(BUF_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign count_o    = cnt_q;
  assign head_dat_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A pop frees the head slot this cycle, so a full buffer may still accept.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/out_mem_rd_ctrl.sv
// Purpose : walks the output memory banks in address order and streams each SYS_COL-wide word to the host.
// Latency : start at edge 0 -> out_rd_en in cycle 1 -> host_valid in cycle 3; then one word per cycle.
// Backpressure: host valid/ready; reads are credit-limited so issued + buffered never exceeds 2.
//
// Ports:
//   clk, rstn                 - clock, asynchronous active-low reset
//   start                     - 1-cycle pulse, begins readback (ignored while busy)
//   num_in, num_out           - output rows, output columns (num_out multiple of SYS_COL)
//   out_rd_en, out_rd_addr    - per-bank read enable / address (all lanes identical)
//   out_rd_data               - per-bank read data, valid the cycle after out_rd_en
//   host_valid, host_ready    - host-side handshake
//   host_data                 - output word, lane i from bank i
//   host_row, host_tile_col   - position tags of host_data
//   host_last                 - marks the final word of the readback
//   busy, done                - readback in progress / 1-cycle completion pulse
module out_mem_rd_ctrl
  import out_mem_rd_ctrl_pkg::*;
#(
  parameter  int SYS_COL    = 16,
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 16,
  localparam int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_out,
  output logic [SYS_COL-1:0]    out_rd_en,
  output logic [ADDR_WIDTH-1:0] out_rd_addr [0:SYS_COL-1],
  input  logic [PSUM_WIDTH-1:0] out_rd_data [0:SYS_COL-1],
  output logic                  host_valid,
  input  logic                  host_ready,
  output logic [PSUM_WIDTH-1:0] host_data   [0:SYS_COL-1],
  output logic [DATA_WIDTH-1:0] host_row,
  output logic [DATA_WIDTH-1:0] host_tile_col,
  output logic                  host_last,
  output logic                  busy,
  output logic                  done
);

  localparam int LOG_COL = $clog2(SYS_COL);
  localparam int TOT_W   = 2 * DATA_WIDTH;
  localparam int WORD_W  = SYS_COL * PSUM_WIDTH;
  localparam int BUF_W   = WORD_W + TAG_W;

  state_e                state_q, state_d;
  logic [TOT_W-1:0]      total_q;
  logic [DATA_WIDTH-1:0] ntc_q;
  logic [TOT_W-1:0]      lin_q;
  logic [DATA_WIDTH-1:0] row_q;
  logic [DATA_WIDTH-1:0] tcol_q;
  logic                  pend_q;      // a read was issued last cycle; its data is on out_rd_data now
  tag_t                  pend_tag_q;  // tags belonging to that in-flight read

  logic [DATA_WIDTH-1:0] ntc_in;
  logic                  load;
  logic                  issue;
  logic                  last_addr;
  logic                  host_pop;
  logic                  credit_ok;
  logic [CNT_W:0]        occ;

  logic [WORD_W-1:0]     rd_word;
  logic [WORD_W-1:0]     head_word;
  tag_t                  head_tag;
  tag_t                  issue_tag;
  logic [BUF_W-1:0]      push_dat;
  logic [BUF_W-1:0]      head_dat;
  logic                  buf_full;
  logic                  buf_empty;
  logic [CNT_W-1:0]      buf_cnt;

  assign ntc_in    = num_out >> LOG_COL;
  assign last_addr = (lin_q == total_q - TOT_W'(1));
  assign host_pop  = host_valid && host_ready;

  // Occupancy seen by the issue side: words in the buffer plus the one read in flight.
  assign occ       = {1'b0, buf_cnt} + {{CNT_W{1'b0}}, pend_q};
  // A pop this cycle frees a slot before the in-flight word lands, so issuing
  // is still safe even at full credit; this is what keeps ready=1 bubble-free.
  assign credit_ok = host_pop || (!buf_full && (occ < (CNT_W + 1)'(BUF_DEPTH)));

  always_comb begin
    issue_tag          = '0;
    issue_tag.row      = IDX_W'(row_q);
    issue_tag.tile_col = IDX_W'(tcol_q);
    issue_tag.last     = last_addr;
  end

  // Next-state / control.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        // total is only known once latched, so an empty readback is detected
        // here and leaves without issuing anything (done lands 2 cycles after start).
        if (total_q == '0) begin
          state_d = ST_FINISH;
        end else if (credit_ok) begin
          issue = 1'b1;
          if (last_addr) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last word is always the final entry to leave the buffer, so its
        // transfer means the buffer is empty and nothing is in flight.
        if (host_pop && head_tag.last) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      total_q    <= '0;
      ntc_q      <= '0;
      lin_q      <= '0;
      row_q      <= '0;
      tcol_q     <= '0;
      pend_q     <= 1'b0;
      pend_tag_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= issue;
      if (issue) begin
        pend_tag_q <= issue_tag;
      end
      if (load) begin
        // The only multiply; per-word addressing is a plain linear counter.
        total_q <= TOT_W'(num_in) * TOT_W'(ntc_in);
        ntc_q   <= ntc_in;
        lin_q   <= '0;
        row_q   <= '0;
        tcol_q  <= '0;
      end else if (issue) begin
        lin_q <= lin_q + TOT_W'(1);
        if (tcol_q == ntc_q - DATA_WIDTH'(1)) begin
          tcol_q <= '0;
          row_q  <= row_q + DATA_WIDTH'(1);
        end else begin
          tcol_q <= tcol_q + DATA_WIDTH'(1);
        end
      end
    end
  end

  assign out_rd_en = {SYS_COL{issue}};

  always_comb begin
    for (int i = 0; i < SYS_COL; i++) begin
      out_rd_addr[i] = ADDR_WIDTH'(lin_q);
    end
  end

  // Lane i of the word occupies bits [i*PSUM_WIDTH +: PSUM_WIDTH].
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < SYS_COL; i++) begin
      rd_word[i*PSUM_WIDTH +: PSUM_WIDTH] = out_rd_data[i];
    end
  end

  assign push_dat = {rd_word, pend_tag_q};

  out_skid_buf #(
    .W (BUF_W)
  ) u_skid (
    .clk_i      (clk),
    .rstn_i     (rstn),
    .push_i     (pend_q),
    .push_dat_i (push_dat),
    .pop_i      (host_pop),
    .head_dat_o (head_dat),
    .full_o     (buf_full),
    .empty_o    (buf_empty),
    .count_o    (buf_cnt)
  );

  assign {head_word, head_tag} = head_dat;

  always_comb begin
    for (int i = 0; i < SYS_COL; i++) begin
      host_data[i] = head_word[i*PSUM_WIDTH +: PSUM_WIDTH];
    end
  end

  assign host_valid    = !buf_empty;
  assign host_row      = DATA_WIDTH'(head_tag.row);
  assign host_tile_col = DATA_WIDTH'(head_tag.tile_col);
  // Gated so a stale head entry can never show last without valid.
  assign host_last     = host_valid && head_tag.last;
  assign busy          = (state_q != ST_IDLE);
  assign done          = (state_q == ST_FINISH);

endmodule
